// File: rtl/mod_addsub_arbiter.sv
// mod_addsub_arbiter
// Two requesters share one modulo-17 add/subtract unit through a round-robin
// arbiter feeding a two-stage pipeline (S1 = operands, S2 = result).
// Optional feature macro: MOD_ADDSUB_RANGE_CHECK_EN
//   defined   -> operands above 16 flag res_err and produce res_data = 0
//   undefined -> res_err tied low, raw 5-bit operands reduced mod 17
module mod_addsub_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [4:0] req0_a,
    input  logic [4:0] req0_b,
    input  logic       req0_sub,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [4:0] req1_a,
    input  logic [4:0] req1_b,
    input  logic       req1_sub,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [4:0] res_data,
    output logic       res_id,
    output logic       res_err
);

    // Round-robin pointer: requester that wins when both are valid
    logic       r_rrPtr;

    // Stage 1: captured operation
    logic       r_s1Valid;
    logic [4:0] r_s1A;
    logic [4:0] r_s1B;
    logic       r_s1Sub;
    logic       r_s1Id;

    // Stage 2: computed result, drives the result port
    logic       r_s2Valid;
    logic [4:0] r_s2Data;
    logic       r_s2Id;
    logic       r_s2Err;

    logic       w_stall;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_accept;
    logic       w_acceptId;
    logic [4:0] w_selA;
    logic [4:0] w_selB;
    logic       w_selSub;
    logic [4:0] w_aRed;
    logic [4:0] w_bRed;
    logic [5:0] w_sum;
    logic [5:0] w_diff;
    logic [4:0] w_result;
    logic       w_err;

    // Fold a 5-bit value (0..31) into 0..16
    function automatic logic [4:0] reduce17(input logic [4:0] x);
        logic [4:0] y;
        y = (x >= 5'd17) ? (x - 5'd17) : x;
        return y;
    endfunction

    // Output valid and readies are forced low while reset is asserted
    assign res_valid  = r_s2Valid & ~rst;
    assign w_stall    = res_valid & ~res_ready;

    // Arbitration: a lone valid requester wins, otherwise the pointer decides
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant0 = ~r_rrPtr;
            w_grant1 = r_rrPtr;
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    assign req0_ready = w_grant0 & ~w_stall & ~rst;
    assign req1_ready = w_grant1 & ~w_stall & ~rst;
    assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_acceptId = w_grant1;

    // Operand mux selecting the granted requester
    always_comb begin
        w_selA   = req0_a;
        w_selB   = req0_b;
        w_selSub = req0_sub;
        if (w_grant1) begin
            w_selA   = req1_a;
            w_selB   = req1_b;
            w_selSub = req1_sub;
        end
    end

    // Modulo-17 arithmetic on the S1 operands, result always in 0..16
    always_comb begin
        w_aRed   = reduce17(r_s1A);
        w_bRed   = reduce17(r_s1B);
        w_sum    = {1'b0, w_aRed} + {1'b0, w_bRed};
        if (w_sum >= 6'd17) begin
            w_sum = w_sum - 6'd17;
        end
        if (w_aRed >= w_bRed) begin
            w_diff = {1'b0, w_aRed} - {1'b0, w_bRed};
        end else begin
            w_diff = {1'b0, w_aRed} + 6'd17 - {1'b0, w_bRed};
        end
        w_result = r_s1Sub ? w_diff[4:0] : w_sum[4:0];
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        w_err = (r_s1A > 5'd16) | (r_s1B > 5'd16);
        if (w_err) begin
            w_result = 5'd0;
        end
`else
        w_err = 1'b0;
`endif
    end

    // Pipeline and pointer update; everything freezes while the result is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr   <= 1'b0;
            r_s1Valid <= 1'b0;
            r_s1A     <= 5'd0;
            r_s1B     <= 5'd0;
            r_s1Sub   <= 1'b0;
            r_s1Id    <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s2Data  <= 5'd0;
            r_s2Id    <= 1'b0;
            r_s2Err   <= 1'b0;
        end else if (!w_stall) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1A   <= w_selA;
                r_s1B   <= w_selB;
                r_s1Sub <= w_selSub;
                r_s1Id  <= w_acceptId;
                r_rrPtr <= ~w_acceptId;
            end
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Data <= w_result;
                r_s2Id   <= r_s1Id;
                r_s2Err  <= w_err;
            end
        end
    end

    assign res_data = r_s2Data;
    assign res_id   = r_s2Id;
    assign res_err  = r_s2Err;

endmodule

// File: doc/mod_addsub_arbiter.md
MOD_ADDSUB_ARBITER -- requirements
Module: mod_addsub_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have ports: req0_valid  in  1  requester 0 operation valid.
REQ-004 SHALL have ports: req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-005 SHALL have ports: req0_a, req0_b  in  5  operands, residues mod 17 (legal 0..16).
REQ-006 SHALL have ports: req0_sub  in  1  0 = a+b, 1 = a-b.
REQ-007 SHALL have ports: req1_valid, req1_ready, req1_a, req1_b, req1_sub  as REQ-003..006, for requester 1.
REQ-008 SHALL have ports: res_valid  out  1  result valid.
REQ-009 SHALL have ports: res_ready  in  1  result consumer ready.
REQ-010 SHALL have ports: res_data  out  5  result, always in 0..16.
REQ-011 SHALL have ports: res_id  out  1  originating requester.
REQ-012 SHALL have ports: res_err  out  1  operand range error flag.

Function
REQ-013 SHALL compute res_data = (a + b) mod 17 when sub=0, (a - b) mod 17 when sub=1, non-negative residue.
REQ-014 SHALL arbitrate round-robin: one grant per cycle; only one valid -> that requester; both valid -> requester pointed to by rr_ptr; rr_ptr moves to the other requester after each accepted grant.
REQ-015 SHALL drive reqN_ready = granted_N AND NOT stall; never both readies high in one cycle.
REQ-016 SHALL treat reqN_valid AND reqN_ready at a rising edge as accepted; operands, sub and id captured at that edge.
REQ-017 SHALL use a 2-register pipeline: S1 holds operands/op/id, S2 holds result/id/err; S2 drives res_*.
REQ-018 SHALL have latency: accepted in cycle k -> res_valid high in cycle k+2 when no stall.
REQ-019 SHALL sustain throughput of 1 op/cycle when res_ready held high.
REQ-020 SHALL define stall = res_valid AND NOT res_ready; on stall S1, S2, rr_ptr hold, res_* stable, both readies low.
REQ-021 SHALL deliver results in acceptance order; no loss or duplication across any stall length.
REQ-022 SHALL let bubbles collapse: empty S2 or empty S1 advances even while stalled downstream registers are empty.
REQ-023 SHALL not advance rr_ptr on cycles with no acceptance.
REQ-024 SHALL hold res_data, res_id, res_err at last value while res_valid low.

Reset
REQ-025 SHALL, when rst high at a rising edge, clear S1/S2 valid, set rr_ptr = 0, res_data = 0, res_id = 0, res_err = 0.
REQ-026 SHALL hold req0_ready, req1_ready, res_valid low in any cycle rst is high.
REQ-027 SHALL discard in-flight operations on reset mid-operation; none emerge after rst drops.
REQ-028 SHALL grant requester 0 first when both valid in first cycle after reset.

Configuration
REQ-029 SHALL support macro MOD_ADDSUB_RANGE_CHECK_EN.
REQ-030 SHALL, with MOD_ADDSUB_RANGE_CHECK_EN defined, flag any operand > 16: res_err = 1, res_data = 0, op still consumes a pipeline slot and keeps order.
REQ-031 SHALL, without the macro, tie res_err to 0, omit check logic, and compute REQ-013 on raw 5-bit operand values (result still 0..16).

Verification
REQ-032 SHALL test: req0 a=9,b=12,sub=0, res_ready=1 -> two cycles later res_valid=1, res_data=4, res_id=0.
REQ-033 SHALL test: req1 a=3,b=10,sub=1 -> res_data=10; a=0,b=16,sub=1 -> 1; a=16,b=16,sub=0 -> 15.
REQ-034 SHALL test: both valid continuously after reset, res_ready=1 -> grants 0,1,0,1,..., res_id alternates, one result per cycle.
REQ-035 SHALL test: pipeline full, res_ready low 3 cycles -> both readies low, res_data/res_id stable; after release all results emerge in order, none lost.
REQ-036 SHALL test: with macro, req0 a=20,b=1 -> res_err=1, res_data=0; next legal op a=1,b=1 -> res_err=0, res_data=2.
REQ-037 SHALL test: rst pulsed 1 cycle with 2 ops in flight -> res_valid low next cycle, no stale result appears, next both-valid grant is requester 0.
